reg_shift_sequencer: RTL and testbench
======================================

// Module: reg_shift_sequencer
// PURPOSE
//  Multi-cycle sequencer for ARM register-specified shifts (shift_operand[4]=1, amount = Rs[7:0]).
//  Sits in EXE beside the Val2 generator, which covers only immediate and constant-shift forms.
//  Shifts Rm iteratively, STEP bits per cycle, with full ARM out-of-range and carry semantics.
//  Holds stall high to freeze the pipeline while it is busy.
// PARAMETERS
//  STEP  8  max bits shifted per SHIFT cycle; legal 1..32
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   synchronous reset, active low
//  start       in   1   request; accepted only in IDLE
//  flush       in   1   abort (branch/flush); returns to IDLE, no done
//  shift_type  in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR
//  shift_amt   in   8   Rs[7:0]
//  val_rm      in   32  operand to shift
//  carry_in    in   1   CPSR C, passed through for amount 0
//  busy        out  1   state != IDLE
//  stall       out  1   busy | (start & ~flush), combinational
//  done        out  1   one-cycle pulse, result/carry_out valid
//  result      out  32  shifted value, held until next accept
//  carry_out   out  1   shifter carry, held with result
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
//  - Reset, including mid-operation: state=IDLE; busy/done=0; result=0; carry_out=0; counter=0.
//  - States: IDLE, SHIFT, DONE.
//  - IDLE & start & ~flush = accept. Latch val_rm, shift_type and carry_in.
//    Compute effective count eff:
//    - LSL/LSR: min(amt, 33)
//    - ASR: min(amt, 32)
//    - ROR: amt[4:0]
//  - Accept with eff==0 -> DONE. Load result=val_rm. Load carry_out as follows:
//    - amt==0: carry_in
//    - ROR with amt!=0 and amt[4:0]==0: val_rm[31]
//  - Accept with eff>0 -> SHIFT; remaining=eff.
//  - SHIFT cycle: s=min(remaining, STEP); shift working reg by s.
//    - LSL/LSR zero-fill; ASR sign-fill; ROR rotate.
//    - carry_out = last bit shifted out (ROR: new bit 31).
//    - remaining -= s; remaining==0 after update -> DONE.
//  - Required ARM results follow naturally from the above:
//    - LSL 32 -> 0, C=Rm[0]; LSL >32 -> 0, C=0
//    - LSR 32 -> 0, C=Rm[31]; LSR >32 -> 0, C=0
//    - ASR >=32 -> {32{Rm[31]}}, C=Rm[31]
//  - DONE: done=1 for exactly one cycle, then IDLE. result/carry_out hold until next accept.
//  - Latency: accept cycle, then ceil(eff/STEP) SHIFT cycles, then 1 DONE cycle.
//    done rises 1+ceil(eff/STEP) cycles after accept (eff==0: 1 cycle). Max 1+ceil(33/STEP).
//  - start while busy: ignored. Caller holds operands stable until done.
//  - flush in any state: next state IDLE, done=0. result/carry_out keep their last values.
//    flush & start in IDLE: flush wins, no accept, stall=0.
//  - flush in DONE cycle: done still asserted that cycle; next state IDLE.
//  - Counter width: 6 bits (0..33). No wrap permitted.
// TESTING (STEP=8 unless stated)
//  - LSL amt=4, Rm=0x8000_000F -> 1 SHIFT cycle, result=0x0000_00F0, C=0, done at accept+2.
//  - LSR amt=32, Rm=0x8000_0001 -> 4 SHIFT cycles, result=0, C=1. Same with amt=40 -> result=0, C=0.
//  - ASR amt=200, Rm=0x8000_0000 -> result=0xFFFF_FFFF, C=1, done at accept+5, stall high throughout.
//  - ROR amt=8, Rm=0x1234_5678 -> 0x7812_3456, C=0. ROR amt=32 -> 0x1234_5678, C=0, done at accept+1.
//  - amt=0, carry_in=1, any type -> result=Rm, C=1. start during busy ignored. flush mid-SHIFT -> IDLE, no done.
//  - rst_n=0 mid-SHIFT -> next edge all outputs 0, IDLE. STEP=1 with LSL amt=33 -> 33 SHIFT cycles, result 0, C=0.

Source files
------------

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle sequencer for ARM register-specified shifts: shifts Rm by Rs[7:0],
// at most STEP bits per cycle, with ARM out-of-range and carry semantics; stalls the pipeline while busy.
module reg_shift_sequencer #(
    parameter int STEP = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [1:0]  shift_type_i,
    input  logic [7:0]  shift_amt_i,
    input  logic [31:0] val_rm_i,
    input  logic        carry_in_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        carry_out_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_LSL = 2'b00;
    localparam logic [1:0] TYPE_LSR = 2'b01;
    localparam logic [1:0] TYPE_ASR = 2'b10;
    localparam logic [1:0] TYPE_ROR = 2'b11;
    localparam logic [5:0] STEP_W   = 6'(STEP);

    state_t      state_q;
    logic [1:0]  shiftType_q;
    logic [5:0]  remaining_q;
    logic [31:0] result_q;
    logic        carryOut_q;

    logic [5:0]  effCount;
    logic        zeroCarry;
    logic [5:0]  stepCount;
    logic [32:0] extLeft;
    logic [32:0] extRight;
    logic [32:0] extArith;
    logic [31:0] rotated;
    logic [31:0] shifted_d;
    logic        shiftCarry_d;
    logic [5:0]  remaining_d;

    // Effective count saturates where further shifting cannot change result or carry.
    always_comb begin
        effCount = 6'd0;
        unique case (shift_type_i)
            TYPE_LSL, TYPE_LSR: effCount = (shift_amt_i > 8'd33) ? 6'd33 : shift_amt_i[5:0];
            TYPE_ASR:           effCount = (shift_amt_i > 8'd32) ? 6'd32 : shift_amt_i[5:0];
            default:            effCount = {1'b0, shift_amt_i[4:0]};
        endcase
    end

    // Zero effective count means either amount 0 (carry passes through) or ROR by a multiple of 32.
    assign zeroCarry = (shift_amt_i == 8'd0) ? carry_in_i : val_rm_i[31];

    always_comb begin
        stepCount    = (remaining_q > STEP_W) ? STEP_W : remaining_q;
        extLeft      = {1'b0, result_q} << stepCount;
        extRight     = {result_q, 1'b0} >> stepCount;
        extArith     = $signed({result_q, 1'b0}) >>> stepCount;
        rotated      = (result_q >> stepCount) | (result_q << (6'd32 - stepCount));
        shifted_d    = result_q;
        shiftCarry_d = carryOut_q;
        unique case (shiftType_q)
            TYPE_LSL: begin
                shifted_d    = extLeft[31:0];
                shiftCarry_d = extLeft[32];
            end
            TYPE_LSR: begin
                shifted_d    = extRight[32:1];
                shiftCarry_d = extRight[0];
            end
            TYPE_ASR: begin
                shifted_d    = extArith[32:1];
                shiftCarry_d = extArith[0];
            end
            default: begin
                shifted_d    = rotated;
                shiftCarry_d = rotated[31];
            end
        endcase
        remaining_d = remaining_q - stepCount;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            shiftType_q <= TYPE_LSL;
            remaining_q <= 6'd0;
            result_q    <= 32'd0;
            carryOut_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shiftType_q <= shift_type_i;
                        result_q    <= val_rm_i;
                        remaining_q <= effCount;
                        if (effCount == 6'd0) begin
                            carryOut_q <= zeroCarry;
                            state_q    <= DONE;
                        end else begin
                            carryOut_q <= carry_in_i;
                            state_q    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    result_q    <= shifted_d;
                    carryOut_q  <= shiftCarry_d;
                    remaining_q <= remaining_d;
                    if (remaining_d == 6'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign stall_o     = busy_o | (start_i & ~flush_i);
    assign result_o    = result_q;
    assign carry_out_o = carryOut_q;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Scoreboard bench for reg_shift_sequencer: ARM shift rules model expected result, carry and done cycle;
// a monitor pops expectations whenever done is seen.
module tb_reg_shift_sequencer;

    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start1;
    logic        flush;
    logic [1:0]  shiftType;
    logic [7:0]  shiftAmt;
    logic [31:0] valRm;
    logic        carryIn;
    logic        busy, stall, done, carryOut;
    logic [31:0] result;
    logic        busy1, stall1, done1, carryOut1;
    logic [31:0] result1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          doneCyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    reg_shift_sequencer #(.STEP(STEP)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush),
        .shift_type_i(shiftType), .shift_amt_i(shiftAmt), .val_rm_i(valRm), .carry_in_i(carryIn),
        .busy_o(busy), .stall_o(stall), .done_o(done), .result_o(result), .carry_out_o(carryOut)
    );

    reg_shift_sequencer #(.STEP(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .flush_i(flush),
        .shift_type_i(shiftType), .shift_amt_i(shiftAmt), .val_rm_i(valRm), .carry_in_i(carryIn),
        .busy_o(busy1), .stall_o(stall1), .done_o(done1), .result_o(result1), .carry_out_o(carryOut1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ARM register-shift rules applied directly to the amount, plus the cycle cost of the operation.
    function automatic void refShift(input logic [1:0] t, input logic [7:0] a, input logic [31:0] rm,
                                     input logic c, output logic [31:0] r, output logic co, output int lat);
        int n;
        int eff;
        n   = int'(a);
        r   = rm;
        co  = c;
        eff = 0;
        case (t)
            2'd0: begin
                eff = (n > 33) ? 33 : n;
                if (n >= 1 && n <= 31) begin r = rm << n; co = rm[32 - n]; end
                else if (n == 32)      begin r = 32'd0;   co = rm[0];      end
                else if (n > 32)       begin r = 32'd0;   co = 1'b0;       end
            end
            2'd1: begin
                eff = (n > 33) ? 33 : n;
                if (n >= 1 && n <= 31) begin r = rm >> n; co = rm[n - 1]; end
                else if (n == 32)      begin r = 32'd0;   co = rm[31];    end
                else if (n > 32)       begin r = 32'd0;   co = 1'b0;      end
            end
            2'd2: begin
                eff = (n > 32) ? 32 : n;
                if (n >= 1 && n <= 31) begin r = 32'($signed(rm) >>> n); co = rm[n - 1]; end
                else if (n >= 32)      begin r = {32{rm[31]}};           co = rm[31];    end
            end
            default: begin
                eff = n % 32;
                if (n != 0) begin
                    if (eff == 0) co = rm[31];
                    else begin
                        r  = (rm >> eff) | (rm << (32 - eff));
                        co = r[31];
                    end
                end
            end
        endcase
        lat = 1 + (eff + STEP - 1) / STEP;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        checkOutput("stall", 32'(stall), 32'(busy | (start & ~flush)));
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_result"}, result, e.res);
                checkOutput({e.name, "_carry"}, 32'(carryOut), 32'(e.c));
                checkOutput({e.name, "_done_cycle"}, 32'(cyc), 32'(e.doneCyc));
            end
        end
    end

    task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic [31:0] rm,
                         input logic c, input string name, input bit expectDone);
        exp_t e;
        int lat;
        @(negedge clk); #1;
        shiftType = t; shiftAmt = a; valRm = rm; carryIn = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (expectDone) begin
            refShift(t, a, rm, c, e.res, e.c, lat);
            e.doneCyc = cyc + lat - 1;
            e.name    = name;
            sb.push_back(e);
        end
    endtask

    // Random start pulses while busy must be ignored; the caller keeps operands stable.
    task automatic waitDone(input bit poke);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            checkOutput("busy_while_active", 32'(busy), 32'd1);
            if (done) begin
                start = 1'b0;
                seen  = 1'b1;
                break;
            end
            if (poke) start = 1'($urandom_range(0, 1));
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [7:0] a, input logic [31:0] rm,
                                 input logic c, input string name, input bit poke);
        logic [31:0] r;
        logic        co;
        int          lat;
        issue(t, a, rm, c, name, 1'b1);
        waitDone(poke);
        refShift(t, a, rm, c, r, co, lat);
        repeat (2) @(negedge clk);
        #1;
        checkOutput({name, "_hold_result"}, result, r);
        checkOutput({name, "_hold_carry"}, 32'(carryOut), 32'(co));
    endtask

    initial begin
        int acc;
        bit seen;
        logic [7:0] amt;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; flush = 1'b0;
        shiftType = 2'd0; shiftAmt = 8'd0; valRm = 32'd0; carryIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_carry", 32'(carryOut), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        applyStimulus(2'd0, 8'd4,   32'h8000_000F, 1'b0, "lsl4",    1'b0);
        applyStimulus(2'd1, 8'd32,  32'h8000_0001, 1'b0, "lsr32",   1'b0);
        applyStimulus(2'd1, 8'd40,  32'h8000_0001, 1'b1, "lsr40",   1'b0);
        applyStimulus(2'd2, 8'd200, 32'h8000_0000, 1'b0, "asr200",  1'b1);
        applyStimulus(2'd3, 8'd8,   32'h1234_5678, 1'b1, "ror8",    1'b0);
        applyStimulus(2'd3, 8'd32,  32'h1234_5678, 1'b1, "ror32",   1'b0);
        applyStimulus(2'd3, 8'd64,  32'h8000_0001, 1'b0, "ror64",   1'b0);
        applyStimulus(2'd0, 8'd32,  32'h0000_0001, 1'b0, "lsl32",   1'b0);
        applyStimulus(2'd0, 8'd33,  32'hFFFF_FFFF, 1'b1, "lsl33",   1'b1);
        applyStimulus(2'd2, 8'd31,  32'h4000_0001, 1'b0, "asr31",   1'b0);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(2'(t), 8'd0, 32'hCAFE_0123, 1'b1, "amt0", 1'b1);
        end

        for (int k = 0; k < 150; k++) begin
            amt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
            applyStimulus(2'($urandom_range(0, 3)), amt, $urandom, 1'($urandom_range(0, 1)), "rand",
                          1'($urandom_range(0, 1)));
        end

        issue(2'd0, 8'd33, $urandom, 1'b0, "flush_shift", 1'b0);
        repeat (2) @(negedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_shift_idle", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);

        @(negedge clk); #1;
        start = 1'b1; flush = 1'b1;
        #1;
        checkOutput("flush_start_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_start_busy", 32'(busy), 32'd0);

        issue(2'd3, 8'd8, 32'hA5A5_0F0F, 1'b0, "flush_done", 1'b1);
        waitDone(1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_done_idle", 32'(busy), 32'd0);

        issue(2'd0, 8'd33, 32'hFFFF_FFFF, 1'b1, "reset_mid", 1'b0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midreset_result", result, 32'd0);
        checkOutput("midreset_carry", 32'(carryOut), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);

        @(negedge clk); #1;
        shiftType = 2'd0; shiftAmt = 8'd33; valRm = 32'hFFFF_FFFF; carryIn = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        acc  = cyc;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (done1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("step1_seen_done", 32'(seen), 32'd1);
        checkOutput("step1_done_cycle", 32'(cyc), 32'(acc + 33));
        checkOutput("step1_result", result1, 32'd0);
        checkOutput("step1_carry", 32'(carryOut1), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
